// File: rtl/lzx_4511_scan_ctrl.sv
// Scan controller sharing one 74HC4511 BCD decoder across NUM_DIGITS multiplexed digits.
// Blanks at each digit changeover, runs a lamp test after reset or on request, and swaps data only at frame boundaries.
module lzx_4511_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int BLANK      = 16,
    parameter int LT_CYCLES  = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    lamp_test_req,
    output logic                    BI_n,
    output logic                    LT_n,
    output logic                    LE,
    output logic [3:0]              D,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int M1   = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CMAX = (M1 > LT_CYCLES) ? M1 : LT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    // S_RST holds the reset output values while rst is asserted; it always hands over to the reset lamp test.
    typedef enum logic [2:0] {S_RST, S_LAMP, S_BLANK, S_SHOW, S_IDLE} state_t;

    typedef logic [NUM_DIGITS-1:0][3:0] bcd_vec_t;

    state_t          st, nst;
    logic [IW-1:0]   idx, nidx;
    logic [CW-1:0]   cnt, ncnt;
    logic            lamp_rst, nlr;
    bcd_vec_t        staged, shadow, nshadow;
    logic            pending;
    logic            boundary;

    always_comb begin
        nst  = st;
        nidx = idx;
        nlr  = lamp_rst;
        case (st)
            S_RST: begin
                nst = S_LAMP;
                nlr = 1'b1;
            end
            S_LAMP: begin
                // The reset lamp test is timed and ignores the request; a requested one follows the level.
                if (lamp_rst ? (cnt == CW'(LT_CYCLES - 1)) : !lamp_test_req) begin
                    nst  = en ? S_BLANK : S_IDLE;
                    nidx = '0;
                    nlr  = 1'b0;
                end
            end
            default: begin
                if (lamp_test_req) begin
                    nst  = S_LAMP;
                    nidx = '0;
                end else if (!en) begin
                    nst  = S_IDLE;
                    nidx = '0;
                end else if (st == S_IDLE) begin
                    nst  = S_BLANK;
                    nidx = '0;
                end else if (st == S_BLANK) begin
                    if (cnt == CW'(BLANK - 1))
                        nst = S_SHOW;
                end else if (cnt == CW'(DWELL - 1)) begin
                    nst  = S_BLANK;
                    nidx = (idx == LAST) ? '0 : idx + IW'(1);
                end
            end
        endcase
        ncnt = (nst != st) ? '0 : cnt + CW'(1);
    end

    // Leaving the last digit's SHOW, or entering BLANK of digit 0 from anywhere else, starts a new frame.
    always_comb begin
        boundary = ((st == S_SHOW) && (idx == LAST) && (nst != S_SHOW)) ||
                   ((nst == S_BLANK) && (nidx == '0) && (st != S_BLANK));
        nshadow = shadow;
        if (boundary) begin
            if (load)
                nshadow = digits_in;
            else if (pending)
                nshadow = staged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_RST;
            idx        <= '0;
            cnt        <= '0;
            lamp_rst   <= 1'b0;
            staged     <= '0;
            pending    <= 1'b0;
            shadow     <= '0;
            BI_n       <= 1'b0;
            LT_n       <= 1'b1;
            LE         <= 1'b0;
            D          <= 4'd0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            st       <= nst;
            idx      <= nidx;
            cnt      <= ncnt;
            lamp_rst <= nlr;
            shadow   <= nshadow;
            if (boundary) begin
                pending <= 1'b0;
            end else if (load) begin
                staged  <= digits_in;
                pending <= 1'b1;
            end

            // Outputs are decoded from the next state so they line up with the state register.
            BI_n       <= 1'b0;
            LT_n       <= 1'b1;
            LE         <= 1'b0;
            D          <= 4'd0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
            case (nst)
                S_LAMP: begin
                    BI_n    <= 1'b1;
                    LT_n    <= 1'b0;
                    dig_sel <= '1;
                end
                S_BLANK: begin
                    D <= nshadow[nidx];
                end
                S_SHOW: begin
                    BI_n       <= 1'b1;
                    LE         <= 1'b1;
                    D          <= nshadow[nidx];
                    dig_sel    <= NUM_DIGITS'(1) << nidx;
                    frame_done <= (nidx == LAST) && (ncnt == CW'(DWELL - 1));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lzx_4511_scan_ctrl.sv
// Scoreboard bench for lzx_4511_scan_ctrl: a frame-position reference model predicts every output cycle.
module tb_lzx_4511_scan_ctrl;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int B  = 2;
    localparam int LT = 4;
    localparam int P  = B + W;
    localparam int FR = N * P;

    logic           clk = 1'b0;
    logic           rst, en, load, lamp_test_req;
    logic [4*N-1:0] digits_in;
    logic           BI_n, LT_n, LE, frame_done;
    logic [3:0]     D;
    logic [N-1:0]   dig_sel;

    always #5 clk = ~clk;

    lzx_4511_scan_ctrl #(.NUM_DIGITS(N), .DWELL(W), .BLANK(B), .LT_CYCLES(LT)) dut (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .load(load),
        .lamp_test_req(lamp_test_req), .BI_n(BI_n), .LT_n(LT_n), .LE(LE), .D(D),
        .dig_sel(dig_sel), .frame_done(frame_done)
    );

    typedef struct {
        logic [N+7:0] v;  // {bi, lt, le, d, sel, fd}
        int           cyc;
        string        ph;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: scan position counted in cycles from the start of the frame.
    typedef enum int {M_RST, M_RLAMP, M_QLAMP, M_SCAN, M_IDLE} mmode_t;
    mmode_t     m_mode = M_RST;
    int         m_lamp = 0;
    int         m_pos = 0;
    logic [3:0] m_sh[N];
    logic [3:0] m_stg[N];
    bit         m_pend = 0;
    logic [15:0] cur_din = 16'h0;

    task automatic model_step(input bit r, input bit e, input bit l, input bit rq,
                              input logic [15:0] din, output logic [N+7:0] ev);
        bit bnd, exit_l, last_show;
        logic bi, lt, le, fd;
        logic [3:0] d;
        logic [N-1:0] sel;
        int dg, wi;
        bnd = 0; exit_l = 0;
        if (r) begin
            m_mode = M_RST;
            m_pend = 0;
            for (int i = 0; i < N; i++) begin m_sh[i] = 0; m_stg[i] = 0; end
        end else begin
            last_show = (m_mode == M_SCAN) && (m_pos >= FR - W);
            case (m_mode)
                M_RST: begin m_mode = M_RLAMP; m_lamp = 1; end
                M_RLAMP: if (m_lamp == LT) exit_l = 1; else m_lamp++;
                M_QLAMP: if (!rq) exit_l = 1;
                default: begin
                    if (rq) begin bnd = last_show; m_mode = M_QLAMP; end
                    else if (!e) begin bnd = last_show; m_mode = M_IDLE; end
                    else if (m_mode == M_IDLE) begin m_mode = M_SCAN; m_pos = 0; bnd = 1; end
                    else begin
                        m_pos++;
                        if (m_pos == FR) begin m_pos = 0; bnd = 1; end
                    end
                end
            endcase
            if (exit_l) begin
                if (e) begin m_mode = M_SCAN; m_pos = 0; bnd = 1; end
                else m_mode = M_IDLE;
            end
            if (bnd) begin
                for (int i = 0; i < N; i++)
                    m_sh[i] = l ? din[4*i +: 4] : (m_pend ? m_stg[i] : m_sh[i]);
                m_pend = 0;
            end else if (l) begin
                for (int i = 0; i < N; i++) m_stg[i] = din[4*i +: 4];
                m_pend = 1;
            end
        end
        bi = 0; lt = 1; le = 0; d = 0; sel = '0; fd = 0;
        if (m_mode == M_RLAMP || m_mode == M_QLAMP) begin
            bi = 1; lt = 0; sel = '1;
        end else if (m_mode == M_SCAN) begin
            dg = m_pos / P;
            wi = m_pos % P;
            d  = m_sh[dg];
            if (wi >= B) begin
                bi = 1; le = 1; sel = N'(1) << dg; fd = (m_pos == FR - 1);
            end
        end
        ev = {bi, lt, le, d, sel, fd};
    endtask

    task automatic step(input bit r, input bit e, input bit l, input bit rq,
                        input logic [15:0] din, input string ph);
        exp_t x;
        rst = r; en = e; load = l; lamp_test_req = rq; digits_in = din;
        model_step(r, e, l, rq, din, x.v);
        x.cyc = cyc; x.ph = ph;
        q.push_back(x);
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit e, input string ph);
        for (int i = 0; i < n; i++) step(0, e, 0, 0, cur_din, ph);
    endtask

    task automatic wait_pos(input int tgt, input string ph);
        int k;
        k = 0;
        while (!(m_mode == M_SCAN && m_pos == tgt) && k < 300) begin
            step(0, 1, 0, 0, cur_din, ph);
            k++;
        end
        if (k == 300) begin
            checks++; failures++;
            $display("FAIL %s timeout waiting for scan pos %0d", ph, tgt);
        end
    endtask

    initial begin : monitor
        exp_t x;
        logic [N+7:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                act = {BI_n, LT_n, LE, D, dig_sel, frame_done};
                checks++;
                if (act !== x.v) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got bi,lt,le,d,sel,fd=%b,%b,%b,%h,%b,%b want %b,%b,%b,%h,%b,%b",
                             x.ph, x.cyc, act[N+7], act[N+6], act[N+5], act[N+4:N+1], act[N:1], act[0],
                             x.v[N+7], x.v[N+6], x.v[N+5], x.v[N+4:N+1], x.v[N:1], x.v[0]);
                end
            end
        end
    end

    initial begin : driver
        bit r_en, r_rq;
        repeat (3) step(1, 1, 0, 0, cur_din, "reset");
        run(14, 1, "rst_release");

        wait_pos(15, "pre_load");
        cur_din = 16'h9510;
        step(0, 1, 1, 0, cur_din, "load_9510");
        run(2 * FR, 1, "frame_9510");

        wait_pos(P + B + 3, "pre_mid_load");
        cur_din = 16'h8765;
        step(0, 1, 1, 0, cur_din, "load_mid_frame");
        run(2 * FR, 1, "frame_8765");

        wait_pos(FR - 1, "pre_boundary_load");
        cur_din = 16'hFA3C;
        step(0, 1, 1, 0, cur_din, "load_on_boundary");
        run(FR + 5, 1, "frame_boundary_load");

        wait_pos(2 * P + B + 2, "pre_en_drop");
        repeat (4) step(0, 0, 0, 0, cur_din, "en_low");
        run(30, 1, "en_raise");

        wait_pos(2 * P + B + 1, "pre_lamp_req");
        repeat (5) step(0, 1, 0, 1, cur_din, "lamp_req");
        run(20, 1, "lamp_release");

        wait_pos(3 * P + B + 4, "pre_mid_rst");
        step(0, 1, 1, 0, 16'h4444, "load_before_rst");
        step(1, 1, 0, 0, cur_din, "mid_rst");
        run(60, 1, "after_mid_rst");

        repeat (2) step(1, 0, 0, 0, cur_din, "reset_en_low");
        run(10, 0, "lamp_then_idle");
        run(20, 1, "idle_to_scan");

        r_en = 1; r_rq = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) r_en = ~r_en;
            if (!r_rq && $urandom_range(0, 199) == 0) r_rq = 1;
            else if (r_rq && $urandom_range(0, 4) == 0) r_rq = 0;
            cur_din = 16'($urandom);
            step($urandom_range(0, 999) < 2, r_en, $urandom_range(0, 19) == 0, r_rq, cur_din, "random");
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain %0d expected responses left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
